// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field widths, compare opcodes, S1 payload
// and the NaN/zero classifiers reused by other FPU units.
package fpu_pkg;

   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;
   localparam int unsigned OP_W  = 2;

   typedef enum logic [OP_W-1:0] {
      CMP_FEQ = 2'd0,
      CMP_FLT = 2'd1,
      CMP_FLE = 2'd2
   } cmp_op_t;

   // Operation payload held in the first pipeline stage (op kept raw so the
   // reserved encoding survives to the compare logic).
   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [FP_W-1:0] x1;
      logic [FP_W-1:0] x2;
   } cmp_req_t;

   function automatic logic is_nan(input logic [FP_W-1:0] x);
      return (x[FP_W-2 -: EXP_W] == '1) && (x[MAN_W-1:0] != '0);
   endfunction

   // Signalling NaN: quiet bit (mantissa MSB) clear.
   function automatic logic is_snan(input logic [FP_W-1:0] x);
      return is_nan(x) && !x[MAN_W-1];
   endfunction

   function automatic logic is_zero(input logic [FP_W-1:0] x);
      return (x[FP_W-2:0] == '0);
   endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational binary32 FEQ/FLT/FLE evaluation.
// Optional invalid flag output when FCMP_FLAGS_EN is defined.
module fcmp_core
   import fpu_pkg::*;
(
   input  logic [OP_W-1:0] op,
   input  logic [FP_W-1:0] x1,
   input  logic [FP_W-1:0] x2,
   output logic            res
`ifdef FCMP_FLAGS_EN
   ,
   output logic            nv
`endif
);

   logic                any_nan;
   logic                both_zero;
   logic                eq;
   logic                lt_raw;
   logic                lt;
   logic [FP_W-2:0]     mag1;
   logic [FP_W-2:0]     mag2;

   // Ordering by sign then magnitude bits; infinities/denormals need no special case.
   always_comb begin
      any_nan   = is_nan(x1) || is_nan(x2);
      both_zero = is_zero(x1) && is_zero(x2);
      mag1      = x1[FP_W-2:0];
      mag2      = x2[FP_W-2:0];
      eq        = !any_nan && ((x1 == x2) || both_zero);
      if (x1[FP_W-1] != x2[FP_W-1]) begin
         lt_raw = x1[FP_W-1];
      end else if (!x1[FP_W-1]) begin
         lt_raw = (mag1 < mag2);
      end else begin
         lt_raw = (mag1 > mag2);
      end
      lt = !any_nan && !both_zero && lt_raw;
   end

   // Result select; reserved opcode yields 0.
   always_comb begin
      res = 1'b0;
      case (op)
         CMP_FEQ: res = eq;
         CMP_FLT: res = lt;
         CMP_FLE: res = lt || eq;
         default: res = 1'b0;
      endcase
   end

`ifdef FCMP_FLAGS_EN
   // FEQ only signals on sNaN; ordered compares signal on any NaN.
   always_comb begin
      nv = 1'b0;
      case (op)
         CMP_FEQ: nv = is_snan(x1) || is_snan(x2);
         CMP_FLT: nv = any_nan;
         CMP_FLE: nv = any_nan;
         default: nv = 1'b0;
      endcase
   end
`endif

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage pipelined binary32 compare with valid/ready on both sides.
// S1 holds the accepted operation, S2 holds the registered result.
// Optional out_nv flag is built when FCMP_FLAGS_EN is defined.
module fcmp_pipe
   import fpu_pkg::*;
#(
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [FP_W-1:0]  in_x1,
   input  logic [FP_W-1:0]  in_x2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [FP_W-1:0]  out_y,
   output logic [TAG_W-1:0] out_tag
`ifdef FCMP_FLAGS_EN
   ,
   output logic             out_nv
`endif
);

   logic             s1_valid_q, s1_valid_d;
   cmp_req_t         s1_req_q,   s1_req_d;
   logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
   logic             out_valid_q, out_valid_d;
   logic [FP_W-1:0]  out_y_q,    out_y_d;
   logic [TAG_W-1:0] out_tag_q,  out_tag_d;
   logic             adv2;
   logic             in_fire;
   logic             cmp_res;
`ifdef FCMP_FLAGS_EN
   logic             cmp_nv;
   logic             out_nv_q, out_nv_d;
`endif

   fcmp_core u_core (
      .op  (s1_req_q.op),
      .x1  (s1_req_q.x1),
      .x2  (s1_req_q.x2),
      .res (cmp_res)
`ifdef FCMP_FLAGS_EN
      ,
      .nv  (cmp_nv)
`endif
   );

   // Handshake: S2 can take S1 when empty or draining; reset blocks intake.
   always_comb begin
      adv2     = s1_valid_q && (!out_valid_q || out_ready);
      in_ready = !rst && (!s1_valid_q || adv2);
      in_fire  = in_valid && in_ready;
   end

   // Next-state for both stages; S2 holds stable while stalled.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_req_d    = s1_req_q;
      s1_tag_d    = s1_tag_q;
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      out_tag_d   = out_tag_q;
`ifdef FCMP_FLAGS_EN
      out_nv_d    = out_nv_q;
`endif
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_req_d   = '{op: in_op, x1: in_x1, x2: in_x2};
         s1_tag_d   = in_tag;
      end else if (adv2) begin
         s1_valid_d = 1'b0;
      end
      if (adv2) begin
         out_valid_d = 1'b1;
         out_y_d     = {{(FP_W-1){1'b0}}, cmp_res};
         out_tag_d   = s1_tag_q;
`ifdef FCMP_FLAGS_EN
         out_nv_d    = cmp_nv;
`endif
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Pipeline registers with synchronous reset discarding in-flight ops.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_req_q    <= '0;
         s1_tag_q    <= '0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_tag_q   <= '0;
`ifdef FCMP_FLAGS_EN
         out_nv_q    <= 1'b0;
`endif
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_req_q    <= s1_req_d;
         s1_tag_q    <= s1_tag_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_tag_q   <= out_tag_d;
`ifdef FCMP_FLAGS_EN
         out_nv_q    <= out_nv_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_tag   = out_tag_q;
`ifdef FCMP_FLAGS_EN
   assign out_nv    = out_nv_q;
`endif

endmodule

// File: tb/tb_fcmp_pipe.sv
// Scoreboard bench for fcmp_pipe: driver pushes expected results on accept,
// a negedge monitor pops and compares on every output transfer.
// Define FCMP_FLAGS_EN to also check out_nv.
module tb_fcmp_pipe;

   localparam int unsigned TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       in_op = '0;
   logic [31:0]      in_x1 = '0;
   logic [31:0]      in_x2 = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      out_y;
   logic [TAG_W-1:0] out_tag;
`ifdef FCMP_FLAGS_EN
   logic             out_nv;
`endif

   always #5 clk = ~clk;

   fcmp_pipe #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_x1     (in_x1),
      .in_x2     (in_x2),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_tag   (out_tag)
`ifdef FCMP_FLAGS_EN
      ,
      .out_nv    (out_nv)
`endif
   );

   typedef struct {
      logic             y;
      logic [TAG_W-1:0] tag;
      logic             nv;
      int               acc;
      bit               lat;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        y;
      logic        nv;
   } vec_t;

   vec_t basic [12] = '{
      '{2'd1, 32'h3F800000, 32'h40000000, 1'b1, 1'b0},  // 1.0 < 2.0
      '{2'd2, 32'hC0000000, 32'hBF800000, 1'b1, 1'b0},  // -2 <= -1
      '{2'd0, 32'h00000000, 32'h80000000, 1'b1, 1'b0},  // +0 == -0
      '{2'd1, 32'h00000000, 32'h80000000, 1'b0, 1'b0},  // +0 < -0 false
      '{2'd2, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b1},  // FLE qNaN
      '{2'd0, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b0},  // FEQ qNaN quiet
      '{2'd0, 32'h7F800001, 32'h3F800000, 1'b0, 1'b1},  // FEQ sNaN
      '{2'd1, 32'hFF800000, 32'h7F800000, 1'b1, 1'b0},  // -inf < +inf
      '{2'd2, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0},  // +inf <= +inf
      '{2'd3, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0},  // reserved op
      '{2'd1, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0},  // -1 < -2 false
      '{2'd1, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1}   // FLT vs qNaN
   };

   vec_t bp [6] = '{
      '{2'd1, 32'h3F800000, 32'h40000000, 1'b1, 1'b0},
      '{2'd1, 32'h40000000, 32'h3F800000, 1'b0, 1'b0},
      '{2'd0, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0},
      '{2'd2, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0},
      '{2'd1, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0},
      '{2'd1, 32'hC0000000, 32'hBF800000, 1'b1, 1'b0}
   };

   exp_t             sb [$];
   exp_t             mon_e;
   int               n_chk = 0;
   int               n_fail = 0;
   int               cyc = 0;
   int               n_out = 0;
   bit               saw_block = 1'b0;
   bit               stall_seen = 1'b0;
   logic [31:0]      st_y;
   logic [TAG_W-1:0] st_tag;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare every output transfer against the scoreboard head and
   // verify stalled outputs do not change.
   always @(negedge clk) begin
      if (rst) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_y", out_y, st_y);
            check("stall_tag", 32'(out_tag), 32'(st_tag));
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               check("unexpected_out_sb_depth", 32'(sb.size()), 32'd1);
            end else begin
               mon_e = sb.pop_front();
               check("out_y", out_y, {31'b0, mon_e.y});
               check("out_tag", 32'(out_tag), 32'(mon_e.tag));
`ifdef FCMP_FLAGS_EN
               check("out_nv", 32'(out_nv), 32'(mon_e.nv));
`endif
               if (mon_e.lat) check("latency", 32'(cyc), 32'(mon_e.acc + 2));
            end
         end
         stall_seen = out_valid && !out_ready;
         st_y       = out_y;
         st_tag     = out_tag;
      end
   end

   // Present one op and hold it until accepted (bounded wait).
   task automatic issue(input vec_t v, input logic [TAG_W-1:0] tag, input bit lat);
      int waits = 0;
      bit done  = 1'b0;
      in_valid = 1'b1;
      in_op    = v.op;
      in_x1    = v.a;
      in_x2    = v.b;
      in_tag   = tag;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{v.y, tag, v.nv, cyc, lat});
            done = 1'b1;
         end else begin
            saw_block = 1'b1;
            waits++;
            if (waits > 50) begin
               check("accept_timeout_in_ready", 32'(in_ready), 32'd1);
               done = 1'b1;
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_sb_depth", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int out_base;
      vec_t tv;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_y", out_y, 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Directed compares, back-to-back with out_ready high
      for (int i = 0; i < 12; i++) issue(basic[i], TAG_W'(i + 1), 1'b1);
      drain();

      // Backpressure: out_ready low on stream cycles 3..6
      saw_block = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) issue(bp[i], TAG_W'(i + 1), 1'b0);
            in_valid = 1'b0;
         end
         begin
            for (int c = 1; c <= 8; c++) begin
               out_ready = !(c >= 3 && c <= 6);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_in_ready_dropped", 32'(saw_block), 32'd1);

      // Throughput: 16 ops, one per cycle, fixed latency each
      saw_block = 1'b0;
      out_base  = n_out;
      for (int i = 0; i < 16; i++) begin
         tv = '{2'd1, 32'(i), 32'd8, (i < 8), 1'b0};
         issue(tv, TAG_W'(i), 1'b1);
      end
      drain();
      check("tp_no_stall", 32'(saw_block), 32'd0);
      check("tp_count", 32'(n_out - out_base), 32'd16);

      // Reset with both stages full
      out_ready = 1'b0;
      issue(basic[0], TAG_W'(20), 1'b0);
      issue(basic[1], TAG_W'(21), 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      check("full_out_valid", 32'(out_valid), 32'd1);
      check("full_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      check("rst_hi_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_y", out_y, 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("rel_in_ready", 32'(in_ready), 32'd1);
      check("rel_out_valid", 32'(out_valid), 32'd0);
      out_base = n_out;
      repeat (5) @(posedge clk);
      #1;
      check("no_stale_out", 32'(n_out - out_base), 32'd0);

      // One op after reset still flows
      issue(basic[7], TAG_W'(30), 1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
